// File: rtl/ex_writeback_unit_pkg.sv
// Shared opcode encodings, write-class and state types for the writeback stage.
// Opcode values stand in for the shared parameters.v encodings.
package ex_writeback_unit_pkg;

    localparam int unsigned OP_W = 5;

    localparam logic [OP_W-1:0] OP_ADD  = 5'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 5'd1;
    localparam logic [OP_W-1:0] OP_NOT  = 5'd2;
    localparam logic [OP_W-1:0] OP_AND  = 5'd3;
    localparam logic [OP_W-1:0] OP_OR   = 5'd4;
    localparam logic [OP_W-1:0] OP_XOR  = 5'd5;
    localparam logic [OP_W-1:0] OP_INC  = 5'd6;
    localparam logic [OP_W-1:0] OP_RR   = 5'd7;
    localparam logic [OP_W-1:0] OP_RL   = 5'd8;
    localparam logic [OP_W-1:0] OP_SETB = 5'd9;
    localparam logic [OP_W-1:0] OP_CLRB = 5'd10;
    localparam logic [OP_W-1:0] OP_CPLB = 5'd11;
    localparam logic [OP_W-1:0] OP_MUL  = 5'd12;
    localparam logic [OP_W-1:0] OP_DIV  = 5'd13;
    localparam logic [OP_W-1:0] OP_CMP  = 5'd14;
    localparam logic [OP_W-1:0] OP_SETF = 5'd15;
    localparam logic [OP_W-1:0] OP_CLRF = 5'd16;
    localparam logic [OP_W-1:0] OP_CPLF = 5'd17;
    localparam logic [OP_W-1:0] OP_LBL  = 5'd18;
    localparam logic [OP_W-1:0] OP_LBH  = 5'd19;
    localparam logic [OP_W-1:0] OP_MOV  = 5'd20;

    typedef enum logic [1:0] {
        WB_NONE       = 2'd0,
        WB_SINGLE     = 2'd1,
        WB_DUAL       = 2'd2,
        WB_FLAGS_ONLY = 2'd3
    } wb_class_e;

    typedef enum logic {
        ST_PRIMARY   = 1'b0,
        ST_SECONDARY = 1'b1
    } wb_state_e;

endpackage

// File: rtl/ex_writeback_unit_wb_class_decode.sv
// Combinational write-class decode: which ports (RF, flags) an ALU bundle retires into.
module ex_writeback_unit_wb_class_decode
    import ex_writeback_unit_pkg::*;
(
    input  logic            alu_en_out,
    input  logic [OP_W-1:0] opcode,
    output wb_class_e       wb_class,
    output logic            flag_wr
);

    always_comb begin
        wb_class = WB_NONE;
        flag_wr  = 1'b0;
        if (alu_en_out) begin
            case (opcode)
                OP_ADD, OP_SUB, OP_NOT, OP_AND, OP_OR, OP_XOR, OP_INC,
                OP_RR, OP_RL, OP_SETB, OP_CLRB, OP_CPLB: begin
                    wb_class = WB_SINGLE;
                    flag_wr  = 1'b1;
                end
                OP_MUL, OP_DIV: begin
                    wb_class = WB_DUAL;
                    flag_wr  = 1'b1;
                end
                OP_CMP, OP_SETF, OP_CLRF, OP_CPLF: begin
                    wb_class = WB_FLAGS_ONLY;
                    flag_wr  = 1'b1;
                end
                default: ;
            endcase
        end else begin
            case (opcode)
                OP_LBL, OP_LBH, OP_MOV: wb_class = WB_SINGLE;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ex_writeback_unit.sv
// Retires ALU bundles into the RF and flag register; MUL/DIV high halves are
// serialised as a second RF beat to rd+1.
module ex_writeback_unit
    import ex_writeback_unit_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_AW = 3,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic              alu_en_out,
    input  logic [OP_W-1:0]   opcode,
    input  logic [REG_AW-1:0] rd,
    input  logic [DATA_W-1:0] result_0,
    input  logic [DATA_W-1:0] result_1,
    input  logic [DATA_W-1:0] next_flags,
    output logic              rf_write_en,
    output logic [REG_AW-1:0] rf_write_addr,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              flag_write_en,
    output logic [DATA_W-1:0] flags_out,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_addr,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  retired_count
);

    wb_state_e         r_state;
    logic              r_rf_we;
    logic [REG_AW-1:0] r_rf_addr;
    logic [DATA_W-1:0] r_rf_data;
    logic              r_flag_we;
    logic [DATA_W-1:0] r_flags;
    logic [REG_AW-1:0] r_hi_addr;
    logic [DATA_W-1:0] r_hi_data;
    logic [CNT_W-1:0]  r_count;

    wb_class_e w_class;
    logic      w_flag_wr;
    logic      w_accept;
    logic      w_rf_wr;

    ex_writeback_unit_wb_class_decode u_wb_class_decode (
        .alu_en_out (alu_en_out),
        .opcode     (opcode),
        .wb_class   (w_class),
        .flag_wr    (w_flag_wr)
    );

    assign ex_ready = reset && (r_state == ST_PRIMARY);
    assign w_accept = ex_valid && ex_ready;
    assign w_rf_wr  = (w_class == WB_SINGLE) || (w_class == WB_DUAL);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_PRIMARY;
            r_rf_we   <= 1'b0;
            r_rf_addr <= '0;
            r_rf_data <= '0;
            r_flag_we <= 1'b0;
            r_flags   <= '0;
            r_hi_addr <= '0;
            r_hi_data <= '0;
            r_count   <= '0;
        end else begin
            case (r_state)
                ST_PRIMARY: begin
                    r_rf_we   <= w_accept && w_rf_wr;
                    r_flag_we <= w_accept && w_flag_wr;
                    if (w_accept) begin
                        if (w_rf_wr) begin
                            r_rf_addr <= rd;
                            r_rf_data <= result_0;
                        end
                        if (w_flag_wr) begin
                            r_flags <= next_flags;
                        end
                        if (w_class == WB_DUAL) begin
                            // High half retires next cycle; address wraps r7 -> r0.
                            r_hi_addr <= rd + REG_AW'(1);
                            r_hi_data <= result_1;
                            r_state   <= ST_SECONDARY;
                        end else begin
                            r_count <= r_count + CNT_W'(1);
                        end
                    end
                end
                ST_SECONDARY: begin
                    r_rf_we   <= 1'b1;
                    r_rf_addr <= r_hi_addr;
                    r_rf_data <= r_hi_data;
                    r_flag_we <= 1'b0;
                    r_count   <= r_count + CNT_W'(1);
                    r_state   <= ST_PRIMARY;
                end
                default: r_state <= ST_PRIMARY;
            endcase
        end
    end

    assign rf_write_en   = r_rf_we;
    assign rf_write_addr = r_rf_addr;
    assign rf_write_data = r_rf_data;
    assign flag_write_en = r_flag_we;
    assign flags_out     = r_flags;
    assign fwd_valid     = r_rf_we;
    assign fwd_addr      = r_rf_addr;
    assign fwd_data      = r_rf_data;
    assign retired_count = r_count;

endmodule

// File: tb/tb_ex_writeback_unit.sv
// Directed bench for ex_writeback_unit: hand-computed expectations per step.
module tb_ex_writeback_unit;
    import ex_writeback_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic        ex_ready;
    logic        alu_en_out;
    logic [4:0]  opcode;
    logic [2:0]  rd;
    logic [15:0] result_0;
    logic [15:0] result_1;
    logic [15:0] next_flags;
    logic        rf_write_en;
    logic [2:0]  rf_write_addr;
    logic [15:0] rf_write_data;
    logic        flag_write_en;
    logic [15:0] flags_out;
    logic        fwd_valid;
    logic [2:0]  fwd_addr;
    logic [15:0] fwd_data;
    logic [15:0] retired_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ex_writeback_unit dut (
        .clk           (clk),
        .reset         (reset),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .alu_en_out    (alu_en_out),
        .opcode        (opcode),
        .rd            (rd),
        .result_0      (result_0),
        .result_1      (result_1),
        .next_flags    (next_flags),
        .rf_write_en   (rf_write_en),
        .rf_write_addr (rf_write_addr),
        .rf_write_data (rf_write_data),
        .flag_write_en (flag_write_en),
        .flags_out     (flags_out),
        .fwd_valid     (fwd_valid),
        .fwd_addr      (fwd_addr),
        .fwd_data      (fwd_data),
        .retired_count (retired_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic en, input logic [4:0] op, input logic [2:0] r,
                         input logic [15:0] r0, input logic [15:0] r1, input logic [15:0] fl);
        ex_valid   = v;
        alu_en_out = en;
        opcode     = op;
        rd         = r;
        result_0   = r0;
        result_1   = r1;
        next_flags = fl;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd31, 3'd0, 16'h0, 16'h0, 16'h0);
    endtask

    task automatic check_rf(input string tag, input logic we, input logic [2:0] a,
                            input logic [15:0] d);
        check({tag, ".rf_we"}, 32'(rf_write_en), 32'(we));
        check({tag, ".addr"}, 32'(rf_write_addr), 32'(a));
        check({tag, ".data"}, 32'(rf_write_data), 32'(d));
        check({tag, ".fwd_valid"}, 32'(fwd_valid), 32'(we));
        check({tag, ".fwd_addr"}, 32'(fwd_addr), 32'(a));
        check({tag, ".fwd_data"}, 32'(fwd_data), 32'(d));
    endtask

    initial begin
        reset = 1'b0;
        idle();
        tick();
        tick();
        // Reset state
        check("rst.ex_ready", 32'(ex_ready), 32'd0);
        check_rf("rst", 1'b0, 3'd0, 16'h0);
        check("rst.flag_we", 32'(flag_write_en), 32'd0);
        check("rst.flags", 32'(flags_out), 32'h0);
        check("rst.count", 32'(retired_count), 32'd0);
        reset = 1'b1;
        #1;
        check("rst.ready_after", 32'(ex_ready), 32'd1);

        // 1: ADD single + flags
        drive(1'b1, 1'b1, OP_ADD, 3'd2, 16'h1234, 16'hFFFF, 16'h0080);
        tick();
        check_rf("add", 1'b1, 3'd2, 16'h1234);
        check("add.flag_we", 32'(flag_write_en), 32'd1);
        check("add.flags", 32'(flags_out), 32'h0080);
        check("add.count", 32'(retired_count), 32'd1);
        idle();
        tick();
        check_rf("idle", 1'b0, 3'd2, 16'h1234);
        check("idle.flag_we", 32'(flag_write_en), 32'd0);
        check("idle.flags", 32'(flags_out), 32'h0080);

        // 2: MUL dual beat
        drive(1'b1, 1'b1, OP_MUL, 3'd3, 16'h5678, 16'h0001, 16'h0042);
        tick();
        idle();
        check_rf("mul.lo", 1'b1, 3'd3, 16'h5678);
        check("mul.lo.flag_we", 32'(flag_write_en), 32'd1);
        check("mul.lo.flags", 32'(flags_out), 32'h0042);
        check("mul.lo.ready", 32'(ex_ready), 32'd0);
        check("mul.lo.count", 32'(retired_count), 32'd1);
        tick();
        check_rf("mul.hi", 1'b1, 3'd4, 16'h0001);
        check("mul.hi.flag_we", 32'(flag_write_en), 32'd0);
        check("mul.hi.ready", 32'(ex_ready), 32'd1);
        check("mul.hi.count", 32'(retired_count), 32'd2);

        // 3: DIV rd=7, high half wraps to r0
        drive(1'b1, 1'b1, OP_DIV, 3'd7, 16'h0003, 16'h0002, 16'h0001);
        tick();
        idle();
        check_rf("div.lo", 1'b1, 3'd7, 16'h0003);
        tick();
        check_rf("div.hi", 1'b1, 3'd0, 16'h0002);
        check("div.count", 32'(retired_count), 32'd3);

        // 4: CMP flags-only, then MOV without flags, then an undecoded op
        drive(1'b1, 1'b1, OP_CMP, 3'd5, 16'hAAAA, 16'h0, 16'h0009);
        tick();
        check("cmp.rf_we", 32'(rf_write_en), 32'd0);
        check("cmp.flag_we", 32'(flag_write_en), 32'd1);
        check("cmp.flags", 32'(flags_out), 32'h0009);
        check("cmp.count", 32'(retired_count), 32'd4);
        drive(1'b1, 1'b0, OP_MOV, 3'd1, 16'hBEEF, 16'h0, 16'hFFFF);
        tick();
        check_rf("mov", 1'b1, 3'd1, 16'hBEEF);
        check("mov.flag_we", 32'(flag_write_en), 32'd0);
        check("mov.flags", 32'(flags_out), 32'h0009);
        check("mov.count", 32'(retired_count), 32'd5);
        drive(1'b1, 1'b0, OP_ADD, 3'd6, 16'h7777, 16'h0, 16'h5555);
        tick();
        check("none.rf_we", 32'(rf_write_en), 32'd0);
        check("none.flag_we", 32'(flag_write_en), 32'd0);
        check("none.count", 32'(retired_count), 32'd6);
        drive(1'b1, 1'b1, OP_MOV, 3'd6, 16'h7777, 16'h0, 16'h5555);
        tick();
        check("none2.rf_we", 32'(rf_write_en), 32'd0);
        check("none2.flag_we", 32'(flag_write_en), 32'd0);
        check("none2.count", 32'(retired_count), 32'd7);

        // 5: reset during SECONDARY drops the high-half write
        drive(1'b1, 1'b1, OP_MUL, 3'd6, 16'h1111, 16'h2222, 16'h0004);
        tick();
        idle();
        check_rf("mulrst.lo", 1'b1, 3'd6, 16'h1111);
        reset = 1'b0;
        tick();
        check_rf("mulrst.rst", 1'b0, 3'd0, 16'h0);
        check("mulrst.flag_we", 32'(flag_write_en), 32'd0);
        check("mulrst.flags", 32'(flags_out), 32'h0);
        check("mulrst.count", 32'(retired_count), 32'd0);
        check("mulrst.ready_low", 32'(ex_ready), 32'd0);
        reset = 1'b1;
        #1;
        check("mulrst.ready_now", 32'(ex_ready), 32'd1);
        tick();
        check("mulrst.no_replay", 32'(rf_write_en), 32'd0);
        check("mulrst.ready", 32'(ex_ready), 32'd1);

        // 6: ten back-to-back XORs
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, OP_XOR, 3'(i), 16'h1000 + 16'(i), 16'h0, 16'(i));
            tick();
            check_rf($sformatf("xor%0d", i), 1'b1, 3'(i), 16'h1000 + 16'(i));
            check($sformatf("xor%0d.ready", i), 32'(ex_ready), 32'd1);
            check($sformatf("xor%0d.count", i), 32'(retired_count), 32'(i + 1));
        end
        idle();
        tick();
        check("xor.final_count", 32'(retired_count), 32'd10);
        check("xor.final_we", 32'(rf_write_en), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
